mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Next-generation MEM-stage data-memory access unit for the 5-stage MIPS pipeline.
- Replaces the single-cycle DM/byte-enable pair with a handshaked, variable-latency memory port.
- Generates byte enables and store lane replication, and aligns and extends load data (lb/lbu/lh/lhu/lw).
- Stalls the pipeline until the access completes and flags bus timeouts.

Parameters:
- ADDR_W, 32: byte-address width; the memory word address is ADDR_W-2 bits.
- TIMEOUT, 16: max cycles spent in REQ+WAIT before a bus error; must be ≥2.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  MEM stage holds a load/store this cycle.
- op_we  in  1  1=store, 0=load.
- op_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- op_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- op_addr  in  ADDR_W  byte address (ALU result).
- op_wdata  in  32  store data (rt value).
- stall  out  1  freeze IF..MEM while an access is in flight.
- ld_data  out  32  aligned, extended load result.
- done  out  1  one-cycle pulse when the access completes.
- bus_err  out  1  one-cycle pulse on timeout; coincides with done.
- misalign  out  1  misaligned access flag (only with MEM_MISALIGN_EXC_EN; otherwise tied 0).
- mem_req  out  1  request to memory.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W-2  word address.
- mem_be  out  4  byte enables, bit i = byte lane i (little endian).
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data word.

Behaviour:
- The FSM has four states: IDLE, REQ, WAIT, DONE. All registered outputs reset to 0 and the state resets to IDLE.
- IDLE:
  - When op_valid=1, latch we/size/unsigned/addr/wdata, clear the counter, and go to REQ.
  - stall=1 combinationally in this cycle.
- REQ:
  - mem_req=1; mem_we/addr/be/wdata are driven from the latched op and held stable until mem_gnt.
  - On mem_gnt with a store, go to DONE.
  - On mem_gnt with a load and mem_rvalid the same cycle, capture the data and go to DONE.
  - On mem_gnt with a load otherwise, go to WAIT.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, capture mem_rdata and go to DONE.
- DONE:
  - stall=0, done=1, ld_data valid; return to IDLE next cycle.
  - op_valid is ignored in DONE, so each instruction gets exactly one access.
- stall = op_valid && state!=DONE.
- Minimum latency:
  - Store: 2 cycles of stall (IDLE, REQ with gnt), then DONE.
  - Load with same-cycle gnt+rvalid: same as a store.
- Timeout:
  - The counter increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT-1 without completion, go to DONE with bus_err=1 and ld_data=0, and deassert mem_req.
- mem_be, indexed by a=addr[1:0]:
  - Byte: 1<<a.
  - Half: 0011 if a[1]=0, else 1100.
  - Word: 1111.
- mem_wdata lane replication:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Load extraction:
  - Byte from lane a.
  - Half from lanes {a[1],1}:{a[1],0}.
  - Extend to 32 bits per op_unsigned.
- ld_data is registered at capture and held until the next capture or reset.
- Without the feature, misaligned addresses simply use the truncated alignment (a[0] ignored for half, a ignored for word).
- A late mem_rvalid arriving in IDLE or REQ for a timed-out access is ignored.
- Asynchronous reset mid-access:
  - Return to IDLE immediately and drop mem_req.
  - No done pulse is produced.
- Reserved size 11 behaves as word.

Optional Feature:
- MEM_MISALIGN_EXC_EN defined:
  - A half access with a[0]=1, or a word access with a≠0, issues no memory request.
  - The FSM goes IDLE→DONE directly with misalign=1 and done=1; ld_data is unchanged and no write occurs.
- Undefined: the misalign port is tied 0 and accesses proceed with truncated alignment.

Decomposition:
- Shared package mem_pkg holds:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encodings S_IDLE, S_REQ, S_WAIT, S_DONE.
- One combinational sub-module, mem_lane_align, computes be, wdata replication, and the load extract/extend. It is reused by the future I-cache refill path.

Test Plan:
- sw 0xDEADBEEF @0x10, gnt on the 1st REQ cycle:
  - mem_be=1111, mem_addr=0x4.
  - stall high 2 cycles, then done=1.
- sb 0x000000A5 @0x13:
  - mem_be=1000, mem_wdata=0xA5A5A5A5.
- lb/lbu/lh/lhu @0x2 with mem_rdata=0x80FF7F01 and rvalid 3 cycles after gnt:
  - Results 0xFFFFFFFF / 0x000000FF / 0xFFFF80FF / 0x000080FF.
  - stall holds until DONE.
- lw with no gnt, TIMEOUT=16:
  - bus_err=done=1 on the 16th REQ/WAIT cycle, ld_data=0.
  - A subsequent spurious rvalid is ignored.
- rst_n pulled low in WAIT:
  - mem_req=0 and state IDLE immediately, no done.
  - The next lw completes normally.
- With MEM_MISALIGN_EXC_EN, lh @0x1:
  - mem_req never asserts.
  - misalign=done=1 one cycle after op_valid.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared encodings for the MEM-stage data-memory access unit.
//   - access size codes used on op_size
//   - FSM state encoding for mem_access_unit
//   - is_misaligned(): natural-alignment test used by the optional
//     misaligned-access exception (MEM_MISALIGN_EXC_EN)
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Reserved size 2'b11 is checked like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational byte-lane steering for a 32-bit little-endian
// memory word. Shared with the I-cache refill path.
//   addr_lo_i   in   2  byte offset within the word
//   size_i      in   2  SZ_BYTE / SZ_HALF / SZ_WORD (11 behaves as word)
//   unsigned_i  in   1  zero-extend (1) or sign-extend (0) load data
//   wdata_i     in  32  raw store data
//   rdata_i     in  32  raw memory read word
//   be_o        out  4  byte enables, bit i = lane i
//   wdata_o     out 32  store data replicated across lanes
//   rdata_o     out 32  extracted and extended load data
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    function automatic logic [31:0] extend8(input logic [7:0] b, input logic uns);
        return uns ? {24'b0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] h, input logic uns);
        return uns ? {16'b0, h} : {{16{h[15]}}, h};
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        // Halfword lane pair is chosen by a[1] only; a[0] is truncated.
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = extend8(byte_sel, unsigned_i);
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = extend16(half_sel, unsigned_i);
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit with a handshaked,
// variable-latency memory port, lane steering, load extension, pipeline stall
// and bus timeout.
// Optional feature macro: MEM_MISALIGN_EXC_EN -- misaligned half/word accesses
// skip the memory and complete immediately with misalign=1.
//   clk, rst_n        clock / asynchronous active-low reset
//   op_valid, op_we, op_size, op_unsigned, op_addr, op_wdata   MEM-stage op
//   stall             freeze IF..MEM while the access is in flight
//   ld_data           aligned, extended load result (held between captures)
//   done, bus_err     completion pulse / timeout pulse (coincides with done)
//   misalign          misaligned-access flag (0 without MEM_MISALIGN_EXC_EN)
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata   request side
//   mem_gnt, mem_rvalid, mem_rdata                 response side
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic              op_we,
    input  logic [1:0]        op_size,
    input  logic              op_unsigned,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [31:0]       op_wdata,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              done,
    output logic              bus_err,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       ld_q;

    logic [3:0]        be_w;
    logic [31:0]       wrep_w;
    logic [31:0]       rext_w;
    logic              timeout_w;

    // Steering works on the latched op so request fields stay stable until gnt.
    mem_lane_align u_align (
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .be_o       (be_w),
        .wdata_o    (wrep_w),
        .rdata_o    (rext_w)
    );

    // Last permitted REQ/WAIT cycle; completion in this cycle still wins.
    assign timeout_w = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MEM_MISALIGN_EXC_EN
    logic mis_q;
    logic misalign_w;
    assign misalign_w = is_misaligned(op_size, op_addr[1:0]);
    assign misalign   = mis_q;
`else
    assign misalign   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= '0;
`ifdef MEM_MISALIGN_EXC_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
            mis_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        we_q    <= op_we;
                        uns_q   <= op_unsigned;
                        size_q  <= op_size;
                        addr_q  <= op_addr;
                        wdata_q <= op_wdata;
                        cnt_q   <= '0;
`ifdef MEM_MISALIGN_EXC_EN
                        if (misalign_w) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            mis_q   <= 1'b1;
                        end else begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                        end
`else
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
`endif
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_gnt && (we_q || mem_rvalid)) begin
                        req_q   <= 1'b0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        if (!we_q) ld_q <= rext_w;
                    end else if (timeout_w) begin
                        req_q   <= 1'b0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        ld_q    <= '0;
                    end else if (mem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_rvalid) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        ld_q    <= rext_w;
                    end else if (timeout_w) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        ld_q    <= '0;
                    end
                end
                S_DONE: begin
                    // op_valid still shows the finished instruction here.
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall     = op_valid && (state_q != S_DONE);
    assign ld_data   = ld_q;
    assign done      = done_q;
    assign bus_err   = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q & req_q;
    assign mem_addr  = addr_q[ADDR_W-1:2];
    assign mem_be    = be_w;
    assign mem_wdata = wrep_w;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int TIMEOUT = 16;
`ifdef MEM_MISALIGN_EXC_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_we, op_unsigned;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        stall, done, bus_err, misalign;
    logic [31:0] ld_data;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_we(op_we), .op_size(op_size),
        .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata),
        .stall(stall), .ld_data(ld_data), .done(done), .bus_err(bus_err),
        .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] last_ld = 32'h0;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          gnt_at;    // REQ cycle index that sees gnt, -1 = never
        int          rv_after;  // cycles from gnt to rvalid, 0 = same cycle
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
        int          exp_stall;
        logic        exp_err;
        logic        exp_mis;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rd, input int g, input int r,
                                input logic [3:0] be, input logic [31:0] ewd,
                                input logic [31:0] eld, input int st, input logic err);
        vec_t v;
        v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd; v.rd = rd;
        v.gnt_at = g; v.rv_after = r; v.exp_be = be; v.exp_wd = ewd;
        v.exp_ld = eld; v.exp_stall = st; v.exp_err = err; v.exp_mis = 1'b0;
        return v;
    endfunction

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == SZ_BYTE) return 1'b0;
        if (sz == SZ_HALF) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == SZ_BYTE) return 4'(1 << (a % 4));
        if (sz == SZ_HALF) return 4'(3 << ((a % 4) / 2 * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] w);
        if (sz == SZ_BYTE) return (w & 32'hFF) * 32'h01010101;
        if (sz == SZ_HALF) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] model_ld(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int bits, ofs;
        if (sz == SZ_BYTE) begin bits = 8; ofs = int'(a % 4); end
        else if (sz == SZ_HALF) begin bits = 16; ofs = int'((a % 4) / 2 * 2); end
        else return rd;
        v = (rd >> (8 * ofs)) & ((32'd1 << bits) - 32'd1);
        if (!uns && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    function automatic vec_t model(input vec_t v);
        int n;
        v.exp_be = model_be(v.sz, v.addr);
        v.exp_wd = model_wd(v.sz, v.wd);
        v.exp_ld = v.we ? 32'h0 : model_ld(v.sz, v.uns, v.addr, v.rd);
        if (v.gnt_at < 0 || (!v.we && v.rv_after < 0)) n = 1000;
        else n = v.gnt_at + 1 + (v.we ? 0 : v.rv_after);
        v.exp_err   = (n > TIMEOUT);
        v.exp_stall = (n > TIMEOUT) ? TIMEOUT + 1 : n + 1;
        return v;
    endfunction

    // Store and misaligned-trap outcomes leave ld_data as it was; timeouts clear it.
    function automatic vec_t adjust(input vec_t v, input logic [31:0] prev);
        if (v.we) v.exp_ld = prev;
        if (v.exp_err) v.exp_ld = 32'h0;
        v.exp_mis = 1'b0;
        if (MIS_EN && model_mis(v.sz, v.addr)) begin
            v.exp_mis = 1'b1; v.exp_stall = 1; v.exp_err = 1'b0; v.exp_ld = prev;
        end
        return v;
    endfunction

    // Entered just after a falling edge; returns just after a falling edge.
    task automatic run_vec(input string tag, input vec_t vin);
        vec_t v;
        int   stall_n, req_n, since;
        bit   granted, seen_done, fields_chk;
        v = adjust(vin, last_ld);
        stall_n = 0; req_n = 0; since = 0;
        granted = 0; seen_done = 0; fields_chk = 0;
        op_valid = 1'b1; op_we = v.we; op_size = v.sz; op_unsigned = v.uns;
        op_addr = v.addr; op_wdata = v.wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (done) begin seen_done = 1; break; end
            if (stall) stall_n++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (mem_req) begin
                if (!fields_chk) begin
                    chk({tag, "_be"},    {28'h0, mem_be}, {28'h0, v.exp_be});
                    chk({tag, "_wdata"}, mem_wdata, v.exp_wd);
                    chk({tag, "_addr"},  {2'b00, mem_addr}, v.addr >> 2);
                    chk({tag, "_we"},    {31'h0, mem_we}, {31'h0, v.we});
                    fields_chk = 1;
                end
                if (req_n == v.gnt_at) begin
                    mem_gnt = 1'b1; granted = 1;
                    if (!v.we && v.rv_after == 0) begin mem_rvalid = 1'b1; mem_rdata = v.rd; end
                end
                req_n++;
            end else if (granted && !v.we) begin
                since++;
                if (since == v.rv_after) begin mem_rvalid = 1'b1; mem_rdata = v.rd; end
            end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, {31'h0, seen_done}, 32'h1);
        if (seen_done) begin
            chk({tag, "_stall_cycles"}, stall_n, v.exp_stall);
            chk({tag, "_ld_data"}, ld_data, v.exp_ld);
            chk({tag, "_bus_err"}, {31'h0, bus_err}, {31'h0, v.exp_err});
            chk({tag, "_misalign"}, {31'h0, misalign}, {31'h0, v.exp_mis});
            chk({tag, "_stall_in_done"}, {31'h0, stall}, 32'h0);
            if (v.exp_mis) chk({tag, "_no_req"}, req_n, 0);
        end
        last_ld = v.exp_ld;
        op_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk); #1;
        chk({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
    endtask

    vec_t tbl[15];

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0, 0, -1, 4'hF, 32'hDEADBEEF, 0, 2, 0);
        tbl[1]  = mk(1, SZ_BYTE, 0, 32'h13, 32'h000000A5, 0, 2, 0, 4'h8, 32'hA5A5A5A5, 0, 4, 0);
        tbl[2]  = mk(0, SZ_BYTE, 0, 32'h2, 0, 32'h80FF7F01, 0, 3, 4'h4, 0, 32'hFFFFFFFF, 5, 0);
        tbl[3]  = mk(0, SZ_BYTE, 1, 32'h2, 0, 32'h80FF7F01, 0, 3, 4'h4, 0, 32'h000000FF, 5, 0);
        tbl[4]  = mk(0, SZ_HALF, 0, 32'h2, 0, 32'h80FF7F01, 0, 3, 4'hC, 0, 32'hFFFF80FF, 5, 0);
        tbl[5]  = mk(0, SZ_HALF, 1, 32'h2, 0, 32'h80FF7F01, 0, 3, 4'hC, 0, 32'h000080FF, 5, 0);
        tbl[6]  = mk(0, SZ_WORD, 0, 32'h8, 0, 32'h12345678, 0, 0, 4'hF, 0, 32'h12345678, 2, 0);
        tbl[7]  = mk(1, SZ_HALF, 0, 32'h6, 32'h1234ABCD, 0, 1, 0, 4'hC, 32'hABCDABCD, 0, 3, 0);
        tbl[8]  = mk(0, SZ_WORD, 0, 32'h40, 0, 32'h11111111, -1, 0, 4'hF, 0, 0, 17, 1);
        tbl[9]  = mk(0, 2'b11, 0, 32'h4, 0, 32'hCAFEF00D, 0, 1, 4'hF, 0, 32'hCAFEF00D, 3, 0);
        tbl[10] = mk(0, SZ_BYTE, 0, 32'h1, 0, 32'h00007F00, 1, 1, 4'h2, 0, 32'h0000007F, 4, 0);
        tbl[11] = mk(0, SZ_WORD, 0, 32'hC, 0, 32'hA1B2C3D4, 15, 0, 4'hF, 0, 32'hA1B2C3D4, 17, 0);
        tbl[12] = mk(0, SZ_WORD, 0, 32'hC, 0, 32'hA1B2C3D4, 15, 1, 4'hF, 0, 0, 17, 1);
        tbl[13] = mk(0, SZ_HALF, 0, 32'h1, 0, 32'h1234F00D, 0, 0, 4'h3, 0, 32'hFFFFF00D, 2, 0);
        tbl[14] = mk(0, SZ_HALF, 1, 32'h3, 0, 32'hBEEF1234, 0, 2, 4'hC, 0, 32'h0000BEEF, 4, 0);

        rst_n = 1'b0; op_valid = 1'b0; op_we = 1'b0; op_size = 2'b00; op_unsigned = 1'b0;
        op_addr = 32'h0; op_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we",  {31'h0, mem_we},  32'h0);
        chk("rst_done",    {31'h0, done},    32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        chk("rst_stall",   {31'h0, stall},   32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Spurious rvalid after a timed-out load must not disturb anything.
        run_vec("to_lw", mk(0, SZ_WORD, 0, 32'h80, 0, 0, -1, 0, 4'hF, 0, 0, 17, 1));
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("late_rvalid_ld", ld_data, last_ld);
        chk("late_rvalid_done", {31'h0, done}, 32'h0);

        // Reset while a request is outstanding drops mem_req at once.
        op_valid = 1'b1; op_we = 1'b0; op_size = SZ_WORD; op_unsigned = 1'b0;
        op_addr = 32'h20; op_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk); #1;
        chk("rstreq_req_up", {31'h0, mem_req}, 32'h1);
        rst_n = 1'b0; #1;
        chk("rstreq_req_drop", {31'h0, mem_req}, 32'h0);
        chk("rstreq_done", {31'h0, done}, 32'h0);
        op_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;

        // Reset while waiting for read data produces no done pulse.
        op_valid = 1'b1;
        @(negedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk); #1;
        mem_gnt = 1'b0;
        chk("rstwait_req_low", {31'h0, mem_req}, 32'h0);
        chk("rstwait_stall", {31'h0, stall}, 32'h1);
        @(negedge clk); #1;
        rst_n = 1'b0; op_valid = 1'b0; #1;
        chk("rstwait_done", {31'h0, done}, 32'h0);
        chk("rstwait_ld", ld_data, 32'h0);
        repeat (2) begin
            @(negedge clk); #1;
            chk("rstwait_no_done", {31'h0, done}, 32'h0);
        end
        rst_n = 1'b1;
        last_ld = 32'h0;
        run_vec("post_rst_lw", mk(0, SZ_WORD, 0, 32'h24, 0, 32'h0BADF00D, 1, 2, 4'hF, 0, 32'h0BADF00D, 5, 0));

        // Randomized transactions against the reference model.
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            int   r;
            v.we = 1'($urandom_range(0, 1)); v.sz = 2'($urandom_range(0, 3));
            v.uns = 1'($urandom_range(0, 1)); v.addr = $urandom; v.wd = $urandom; v.rd = $urandom;
            r = int'($urandom_range(0, 9));
            if (r == 9) v.gnt_at = -1;
            else if (r == 8) v.gnt_at = int'($urandom_range(12, 17));
            else v.gnt_at = int'($urandom_range(0, 3));
            v.rv_after = int'($urandom_range(0, 4));
            run_vec($sformatf("rnd%0d", i), model(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
